mac_array_ctrl: RTL and testbench
=================================

Name: mac_array_ctrl

Overview:
- Sequences one tile operation on the 8x8 weight-stationary MAC array.
- Loads one kernel from weight SRAM, then streams `len` activation vectors from activation SRAM with execute instructions.
- Counts the array's valid outputs until the tile drains, then pulses `done`.
- Sits between the top-level core FSM and the `mac_array` inst_w, mode_2b and SRAM-address inputs.

Parameters:
- row, 8, MAC array rows (pipeline depth of inst_w).
- col, 8, MAC array columns (kernel-load cycles).
- addr_bw, 11, SRAM address width; also the width of `len`.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a tile; ignored unless the FSM is in IDLE.
- len  input  addr_bw  number of activation vectors; sampled on an accepted start.
- w_base  input  addr_bw  first weight-SRAM address; sampled on an accepted start.
- x_base  input  addr_bw  first activation-SRAM address; sampled on an accepted start.
- mode_2b_in  input  1  precision mode; sampled on an accepted start.
- ofifo_full  input  1  output FIFO full; stalls EXEC issue.
- valid_in  input  col  `mac_array` valid bus; only bit col-1 is used.
- w_cen  output  1  weight SRAM chip enable, active-low.
- w_addr  output  addr_bw  weight SRAM address.
- x_cen  output  1  activation SRAM chip enable, active-low.
- x_addr  output  addr_bw  activation SRAM address.
- inst_w  output  2  array instruction: bit1 = execute, bit0 = kernel load.
- mode_2b  output  1  latched mode; held constant for the whole tile.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset values:
  - w_cen = x_cen = 1.
  - w_addr = x_addr = 0.
  - inst_w = 00, mode_2b = 0, busy = 0, done = 0.
  - State = IDLE; all counters = 0.
- SRAM read latency is 1 cycle. inst_w therefore trails the matching address/cen by exactly 1 cycle, so the instruction is aligned with the SRAM output data.
- IDLE:
  - start with len != 0 → latch len, bases and mode; go to KLOAD.
  - start with len == 0 → done = 1 on the next cycle; stay in IDLE; no SRAM access.
- KLOAD, col cycles:
  - w_cen = 0; w_addr = w_base + k for k = 0..col-1.
  - inst_w = 01 in cycles k+1. The last 01 is issued in the first KGAP cycle.
  - Go to KGAP after k = col-1.
- KGAP, row cycles:
  - Cens high; inst_w = 00 after the trailing 01.
  - Lets the load instruction propagate through all rows.
  - Then go to EXEC.
- EXEC:
  - Issue counter n runs 0..len-1.
  - Each cycle with ofifo_full = 0: x_cen = 0, x_addr = x_base + n, n++; the next cycle has inst_w = 10.
  - Each cycle with ofifo_full = 1: x_cen = 1, n held; the next cycle has inst_w = 00 (bubble). Stalls are unbounded.
  - After issuing n = len-1 → DRAIN.
- DRAIN:
  - inst_w = 00 once the final 10 has been emitted.
  - Output counter m increments on every cycle with valid_in[col-1] = 1, in both EXEC and DRAIN.
  - When m reaches len → DONE.
  - Valid pulses beyond len are ignored.
- DONE: done = 1 and busy = 0 for one cycle; return to IDLE. start is accepted again on the following cycle.
- Address arithmetic is modulo 2^addr_bw (wrap, no error).
- mode_2b is updated only on an accepted start.
- start while busy is dropped; it is not queued.
- reset asserted in any state:
  - Next cycle, all outputs are at reset values and the FSM is in IDLE.
  - Partial tile is discarded; no done pulse.
  - The bench reset also clears the array.
- Counters n and m are addr_bw+1 bits wide so len = 2^addr_bw - 1 does not overflow.

Test Plan:
- Basic tile:
  - Stimulus: reset, then start with len = 4, w_base = 0x010, x_base = 0x100, mode_2b_in = 1; valid_in[7] driven by an array model.
  - Required: w_addr 0x010..0x017 on 8 consecutive cycles with w_cen = 0.
  - Required: inst_w = 01 for 8 cycles, each 1 cycle after its address, then 8 cycles of 00.
  - Required: x_addr 0x100..0x103 and inst_w = 10 for 4 cycles.
  - Required: done pulses once, on the cycle after the 4th valid; mode_2b = 1 throughout.
- Back-pressure:
  - Stimulus: len = 6; ofifo_full high for 3 cycles after the 2nd EXEC issue.
  - Required: x_addr holds at x_base + 2 with x_cen = 1; exactly 3 inst_w = 00 bubbles appear; 6 total 10 instructions issued; done follows the 6th valid.
- Zero length / busy:
  - Stimulus: start with len = 0.
  - Required: done next cycle, no cen activity, busy stays 0.
  - Stimulus: start pulsed again mid-EXEC of a len = 3 tile.
  - Required: ignored; exactly one done.
- Wrap:
  - Stimulus: x_base = 0x7FE, len = 4.
  - Required: x_addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
- Reset mid-operation:
  - Stimulus: assert reset during KGAP, then during DRAIN.
  - Required: next cycle inst_w = 00, cens = 1, busy = 0, no done.
  - Required: a subsequent start with len = 2 completes normally.
- Excess valids:
  - Stimulus: array model emits 5 valids for len = 4.
  - Required: done after the 4th valid only; FSM in IDLE when the 5th arrives.

Source files
------------

// File: rtl/mac_array_ctrl.sv
// Purpose: sequences one tile on the 8x8 weight-stationary MAC array: kernel load, activation stream, drain, done.
// Latency: SRAM cen/addr are registered; inst_w trails its cen/addr by one cycle; done one cycle after the last valid.
// Backpressure: ofifo_full stalls activation issue (x_cen high, 00 bubble follows); stalls may last indefinitely.
module mac_array_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] len,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic               mode_2b_in,
  input  logic               ofifo_full,
  input  logic [col-1:0]     valid_in,
  output logic               w_cen,
  output logic [addr_bw-1:0] w_addr,
  output logic               x_cen,
  output logic [addr_bw-1:0] x_addr,
  output logic [1:0]         inst_w,
  output logic               mode_2b,
  output logic               busy,
  output logic               done
);

  localparam int CW = (col > 1) ? $clog2(col) : 1;
  localparam int RW = (row > 1) ? $clog2(row) : 1;

  typedef enum logic [2:0] {IDLE, KLOAD, KGAP, EXEC, DRAIN, DONE} state_t;

  state_t             state;
  logic [addr_bw-1:0] len_q;
  logic [addr_bw-1:0] x_base_q;
  logic [CW-1:0]      k_cnt;
  logic [RW-1:0]      g_cnt;
  logic [addr_bw:0]   n_cnt;
  logic [addr_bw:0]   m_cnt;
  logic [addr_bw:0]   n_inc;
  logic [addr_bw:0]   m_next;
  logic [addr_bw:0]   len_ext;
  logic               issue_slot;
  logic               issue;
  logic               last_issue;
  logic               out_vld;
  logic               unused_valid;

  // The last KGAP cycle already issues the first activation read so that exactly
  // row idle instructions separate the final kernel load from the first execute.
  assign len_ext      = {1'b0, len_q};
  assign issue_slot   = (state == EXEC) || ((state == KGAP) && (g_cnt == RW'(row - 1)));
  assign issue        = issue_slot && !ofifo_full;
  assign n_inc        = n_cnt + (addr_bw + 1)'(1);
  assign last_issue   = issue && (n_inc == len_ext);
  assign out_vld      = valid_in[col-1] && ((state == EXEC) || (state == DRAIN)) && (m_cnt < len_ext);
  assign m_next       = m_cnt + {{addr_bw{1'b0}}, out_vld};
  assign unused_valid = ^valid_in[col-2:0];

  // Tile sequencer: all outputs registered; inst_w is the previous cycle's SRAM enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      x_base_q <= '0;
      k_cnt    <= '0;
      g_cnt    <= '0;
      n_cnt    <= '0;
      m_cnt    <= '0;
      w_cen    <= 1'b1;
      w_addr   <= '0;
      x_cen    <= 1'b1;
      x_addr   <= '0;
      inst_w   <= 2'b00;
      mode_2b  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inst_w <= {~x_cen, ~w_cen};
      done   <= 1'b0;
      m_cnt  <= m_next;

      // Activation issue: address always shows the next vector, cen reflects room in the output FIFO.
      if (issue_slot) begin
        x_cen  <= ofifo_full;
        x_addr <= x_base_q + n_cnt[addr_bw-1:0];
        if (issue) n_cnt <= n_inc;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q    <= len;
              x_base_q <= x_base;
              mode_2b  <= mode_2b_in;
              w_cen    <= 1'b0;
              w_addr   <= w_base;
              k_cnt    <= '0;
              g_cnt    <= '0;
              n_cnt    <= '0;
              m_cnt    <= '0;
              busy     <= 1'b1;
              state    <= KLOAD;
            end else begin
              done <= 1'b1;
            end
          end
        end
        KLOAD: begin
          if (k_cnt == CW'(col - 1)) begin
            w_cen <= 1'b1;
            g_cnt <= '0;
            state <= KGAP;
          end else begin
            k_cnt  <= k_cnt + CW'(1);
            w_addr <= w_addr + addr_bw'(1);
          end
        end
        KGAP: begin
          if (g_cnt == RW'(row - 1)) begin
            state <= last_issue ? DRAIN : EXEC;
          end else begin
            g_cnt <= g_cnt + RW'(1);
          end
        end
        EXEC: begin
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          x_cen <= 1'b1;
          if (m_next == len_ext) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Purpose: directed and randomized tiles against a trace-based reference of mac_array_ctrl.
// Latency: outputs sampled on the falling edge; inputs for each cycle driven on the same falling edge.
// Backpressure: ofifo_full driven directed or random; the array model returns valids a fixed delay after execute.
module tb_mac_array_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] len;
  logic [AW-1:0] w_base;
  logic [AW-1:0] x_base;
  logic          mode_2b_in;
  logic          ofifo_full;
  logic [COL-1:0] valid_in;
  logic          w_cen;
  logic [AW-1:0] w_addr;
  logic          x_cen;
  logic [AW-1:0] x_addr;
  logic [1:0]    inst_w;
  logic          mode_2b;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_array_ctrl #(.row(ROW), .col(COL), .addr_bw(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .w_base    (w_base),
    .x_base    (x_base),
    .mode_2b_in(mode_2b_in),
    .ofifo_full(ofifo_full),
    .valid_in  (valid_in),
    .w_cen     (w_cen),
    .w_addr    (w_addr),
    .x_cen     (x_cen),
    .x_addr    (x_addr),
    .inst_w    (inst_w),
    .mode_2b   (mode_2b),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base, input int off);
    return base + AW'(off);
  endfunction

  // One tile: drive start, run the array/backpressure model per cycle, record a trace, then
  // compare the trace against the expected address/instruction/done sequences.
  task automatic run_tile(input string name, input int len_i, input logic [AW-1:0] wb,
                          input logic [AW-1:0] xb, input logic md, input int stall_mode,
                          input int lat, input bit extra, input bit mid_start, input int rst_phase);
    int   wq_addr[$];
    int   wq_it[$];
    int   xq_addr[$];
    int   xq_it[$];
    int   ld_it[$];
    int   ex_it[$];
    int   vsched[$];
    int   v_it[$];
    int   done_cnt   = 0;
    int   done_it    = -1;
    int   rst_it     = -1;
    int   stall_it   = -1;
    int   stall_left = 0;
    int   bub_exp;
    logic pw = 1'b1;
    logic px = 1'b1;
    logic pf = 1'b0;
    logic v;
    bit   finished   = 1'b0;
    bit   rogue_sent = 1'b0;

    @(negedge clk);
    start = 1'b1; len = AW'(len_i); w_base = wb; x_base = xb; mode_2b_in = md;
    ofifo_full = 1'b0; valid_in = '0;

    for (int it = 1; it <= 3000 && !finished; it++) begin
      @(negedge clk);
      start = 1'b0;
      len = AW'($urandom); w_base = AW'($urandom); x_base = AW'($urandom); mode_2b_in = 1'($urandom);

      if (rst_it >= 0) begin
        reset = 1'b0; valid_in = '0; ofifo_full = 1'b0;
        if (it == rst_it + 1) begin
          chk({name, "_rst_inst"}, inst_w, 2'b00);
          chk({name, "_rst_wcen"}, w_cen, 1'b1);
          chk({name, "_rst_xcen"}, x_cen, 1'b1);
        end
        chk({name, "_rst_busy"}, busy, 1'b0);
        chk({name, "_rst_no_done"}, done, 1'b0);
        if (it == rst_it + 6) finished = 1'b1;
        continue;
      end

      chk({name, "_inst_trails_cen"}, inst_w, {~px, ~pw});
      if (!x_cen) chk({name, "_issue_needs_room"}, pf, 1'b0);
      if (busy) chk({name, "_mode_hold"}, mode_2b, md);
      if (done) begin
        done_cnt++; done_it = it;
        chk({name, "_done_not_busy"}, busy, 1'b0);
      end
      if (stall_it >= 0 && it > stall_it && it <= stall_it + 3) begin
        chk({name, "_stall_xcen"}, x_cen, 1'b1);
        chk({name, "_stall_xaddr"}, x_addr, addr_of(xb, 2));
      end

      if (!w_cen) begin wq_addr.push_back(int'(w_addr)); wq_it.push_back(it); end
      if (!x_cen) begin xq_addr.push_back(int'(x_addr)); xq_it.push_back(it); end
      if (inst_w == 2'b01) ld_it.push_back(it);
      if (inst_w == 2'b10) begin ex_it.push_back(it); vsched.push_back(it + lat); end

      v = 1'b0;
      if (vsched.size() > 0 && vsched[0] == it) begin
        void'(vsched.pop_front());
        v = 1'b1;
        v_it.push_back(it);
        if (v_it.size() == len_i + 1) chk({name, "_excess_valid_idle"}, {busy, done}, 2'b00);
        if (extra && v_it.size() == len_i) vsched.push_back(it + 2);
      end
      valid_in = {v, (COL-1)'($urandom)};

      if (stall_mode == 1) begin
        if (stall_it < 0 && !x_cen && xq_addr.size() == 2) begin stall_it = it; stall_left = 3; end
        ofifo_full = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else if (stall_mode == 2) begin
        ofifo_full = ($urandom_range(0, 2) == 0);
      end else begin
        ofifo_full = 1'b0;
      end

      if (mid_start && !rogue_sent && xq_addr.size() == 1) begin
        start = 1'b1; len = AW'(9); mode_2b_in = ~md; rogue_sent = 1'b1;
      end

      if ((rst_phase == 1 && wq_addr.size() == COL && w_cen) ||
          (rst_phase == 2 && ex_it.size() == len_i && v_it.size() < len_i)) begin
        reset = 1'b1; rst_it = it; vsched.delete();
      end

      pw = w_cen; px = x_cen; pf = ofifo_full;
      if (rst_phase == 0 && done_cnt > 0 && it >= done_it + 4) finished = 1'b1;
    end

    start = 1'b0; ofifo_full = 1'b0; valid_in = '0; reset = 1'b0;
    if (!finished) chk({name, "_timeout"}, 1'b0, 1'b1);

    if (finished && rst_phase == 0) begin
      chk({name, "_done_count"}, done_cnt, 1);
      chk({name, "_w_count"}, wq_addr.size(), COL);
      for (int k = 0; k < COL && k < wq_addr.size(); k++) begin
        chk({name, "_w_addr"}, wq_addr[k], addr_of(wb, k));
        chk({name, "_w_consec"}, wq_it[k], wq_it[0] + k);
      end
      chk({name, "_ld_count"}, ld_it.size(), COL);
      for (int k = 0; k < COL && k < ld_it.size() && k < wq_it.size(); k++)
        chk({name, "_ld_align"}, ld_it[k], wq_it[k] + 1);
      chk({name, "_x_count"}, xq_addr.size(), len_i);
      for (int n = 0; n < len_i && n < xq_addr.size(); n++)
        chk({name, "_x_addr"}, xq_addr[n], addr_of(xb, n));
      chk({name, "_ex_count"}, ex_it.size(), len_i);
      for (int n = 0; n < len_i && n < ex_it.size() && n < xq_it.size(); n++)
        chk({name, "_ex_align"}, ex_it[n], xq_it[n] + 1);
      if (v_it.size() >= len_i) chk({name, "_done_time"}, done_it, v_it[len_i-1] + 1);
      if (ex_it.size() == len_i && xq_it.size() == len_i && ld_it.size() == COL) begin
        if (stall_mode != 2) chk({name, "_kgap_len"}, ex_it[0] - ld_it[COL-1] - 1, ROW);
        bub_exp = (stall_mode == 1) ? 3 :
                  (stall_mode == 0) ? 0 : (xq_it[len_i-1] - xq_it[0] + 1 - len_i);
        chk({name, "_bubbles"}, ex_it[len_i-1] - ex_it[0] + 1 - len_i, bub_exp);
      end
      if (extra) chk({name, "_fifth_valid_seen"}, v_it.size(), len_i + 1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; w_base = '0; x_base = '0;
    mode_2b_in = 1'b0; ofifo_full = 1'b0; valid_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_wcen", w_cen, 1'b1);
    chk("reset_xcen", x_cen, 1'b1);
    chk("reset_waddr", w_addr, '0);
    chk("reset_xaddr", x_addr, '0);
    chk("reset_inst", inst_w, 2'b00);
    chk("reset_mode", mode_2b, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run_tile("basic", 4, 11'h010, 11'h100, 1'b1, 0, 12, 1'b0, 1'b0, 0);
    run_tile("bp", 6, 11'h020, 11'h200, 1'b0, 1, 10, 1'b0, 1'b0, 0);

    @(negedge clk);
    start = 1'b1; len = '0; mode_2b_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_cens", {w_cen, x_cen}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zero_done_once", done, 1'b0);
      chk("zero_idle", {busy, w_cen, x_cen, inst_w}, 5'b01100);
    end

    run_tile("midstart", 3, 11'h040, 11'h300, 1'b1, 0, 9, 1'b0, 1'b1, 0);
    run_tile("wrap", 4, 11'h7FC, 11'h7FE, 1'b0, 0, 11, 1'b0, 1'b0, 0);
    run_tile("rst_kgap", 4, 11'h050, 11'h150, 1'b1, 0, 10, 1'b0, 1'b0, 1);
    run_tile("rst_drain", 5, 11'h060, 11'h160, 1'b0, 0, 15, 1'b0, 1'b0, 2);
    run_tile("after_rst", 2, 11'h070, 11'h170, 1'b1, 0, 10, 1'b0, 1'b0, 0);
    run_tile("excess", 4, 11'h080, 11'h180, 1'b0, 0, 10, 1'b1, 1'b0, 0);

    for (int t = 0; t < 6; t++)
      run_tile("rand", $urandom_range(1, 20), AW'($urandom), AW'($urandom), 1'($urandom),
               2, $urandom_range(2, 20), 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
